// File: rtl/stage_controller.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the MIPS core: latches one instruction,
// drives ALU controls and register/memory/PC strobes, and halts on illegal ops or MEM stalls.
module stage_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       stage,
  output logic [1:0]       alu_op,
  output logic [5:0]       alu_funct,
  output logic             ALU_Src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             pc_write,
  output logic             pc_branch,
  output logic             instr_done,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);

  // state  | meaning
  // S_IF   | wait for instr_valid, latch instruction and ALU controls
  // S_ID   | check opcode legality
  // S_EX   | ALU computes on the edge leaving this state
  // S_MEM  | lw/sw handshake with timeout, or branch resolve (retires sw/branch)
  // S_WB   | register write-back, retires R/addi/lw
  // S_HALT | illegal opcode or MEM timeout, held until reset
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  localparam logic [2:0] ST_IF  = 3'd0;
  localparam logic [2:0] ST_ID  = 3'd1;
  localparam logic [2:0] ST_EX  = 3'd2;
  localparam logic [2:0] ST_MEM = 3'd3;
  localparam logic [2:0] ST_WB  = 3'd4;

  localparam int             TMR_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(MEM_TIMEOUT - 1);

  state_t           state;
  logic [5:0]       opcode_q;
  logic [TMR_W-1:0] tmr_q;

  logic [5:0] in_op;
  logic [1:0] in_alu_op;
  logic       in_src;
  logic       is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_br, legal_q;
  logic       in_mem;
  logic       unused_instr;

  assign in_op        = instr[31:26];
  assign unused_instr = ^instr[25:6];

  always_comb begin
    in_alu_op = 2'b00;
    in_src    = 1'b0;
    case (in_op)
      OP_ADDI, OP_LW, OP_SW: begin
        in_alu_op = 2'b11;
        in_src    = 1'b1;
      end
      OP_BEQ, OP_BNE: in_alu_op = 2'b01;
      default: ;
    endcase
  end

  assign is_r    = (opcode_q == OP_R);
  assign is_addi = (opcode_q == OP_ADDI);
  assign is_lw   = (opcode_q == OP_LW);
  assign is_sw   = (opcode_q == OP_SW);
  assign is_beq  = (opcode_q == OP_BEQ);
  assign is_bne  = (opcode_q == OP_BNE);
  assign is_br   = is_beq | is_bne;
  assign legal_q = is_r | is_addi | is_lw | is_sw | is_br;

  // sw and branches retire in the same MEM cycle that samples mem_ready/zero,
  // so their PC strobes are decoded from live inputs rather than registered.
  assign in_mem     = (state == S_MEM);
  assign pc_branch  = in_mem && ((is_beq && zero) || (is_bne && !zero));
  assign pc_write   = reg_write || (in_mem && (is_br || (is_sw && mem_ready)));
  assign instr_done = pc_write;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IF;
      stage     <= ST_IF;
      opcode_q  <= '0;
      alu_op    <= '0;
      alu_funct <= '0;
      ALU_Src   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      reg_write <= 1'b0;
      error     <= 1'b0;
      tmr_q     <= '0;
    end else begin
      case (state)
        S_IF: begin
          if (instr_valid) begin
            opcode_q  <= in_op;
            alu_op    <= in_alu_op;
            alu_funct <= (in_op == OP_R) ? instr[5:0] : 6'd0;
            ALU_Src   <= in_src;
            state     <= S_ID;
            stage     <= ST_ID;
          end
        end
        S_ID: begin
          if (legal_q) begin
            state <= S_EX;
            stage <= ST_EX;
          end else begin
            state     <= S_HALT;
            stage     <= ST_IF;
            error     <= 1'b1;
            alu_op    <= '0;
            alu_funct <= '0;
            ALU_Src   <= 1'b0;
          end
        end
        S_EX: begin
          if (is_r || is_addi) begin
            state     <= S_WB;
            stage     <= ST_WB;
            reg_write <= 1'b1;
          end else begin
            state     <= S_MEM;
            stage     <= ST_MEM;
            mem_read  <= is_lw;
            mem_write <= is_sw;
            tmr_q     <= TMR_LOAD;
          end
        end
        S_MEM: begin
          if (is_br) begin
            state <= S_IF;
            stage <= ST_IF;
          end else if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (is_lw) begin
              state     <= S_WB;
              stage     <= ST_WB;
              reg_write <= 1'b1;
            end else begin
              state <= S_IF;
              stage <= ST_IF;
            end
          end else if (tmr_q == '0) begin
            state     <= S_HALT;
            stage     <= ST_IF;
            error     <= 1'b1;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            alu_op    <= '0;
            alu_funct <= '0;
            ALU_Src   <= 1'b0;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
        end
        S_WB: begin
          reg_write <= 1'b0;
          state     <= S_IF;
          stage     <= ST_IF;
        end
        S_HALT: state <= S_HALT;
        default: begin
          state <= S_HALT;
          stage <= ST_IF;
          error <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_count <= '0;
    end else if (pc_write) begin
      instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_stage_controller.sv
// Randomized scoreboard bench for stage_controller: a driver issues instructions and
// queues the expected retire/halt events; a negedge monitor pops and compares them.
module tb_stage_controller;
  localparam int CNT_W = 4;
  localparam int TO    = 16;

  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic [31:0]       instr = '0;
  logic              instr_valid = 1'b0;
  logic              zero = 1'b0;
  logic              mem_ready = 1'b0;
  logic [2:0]        stage;
  logic [1:0]        alu_op;
  logic [5:0]        alu_funct;
  logic              ALU_Src;
  logic              mem_read, mem_write, reg_write, pc_write, pc_branch, instr_done, error;
  logic [CNT_W-1:0]  instr_count;

  always #5 clock = ~clock;

  stage_controller #(.MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
    .zero(zero), .mem_ready(mem_ready), .stage(stage), .alu_op(alu_op),
    .alu_funct(alu_funct), .ALU_Src(ALU_Src), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .pc_write(pc_write),
    .pc_branch(pc_branch), .instr_done(instr_done), .error(error),
    .instr_count(instr_count)
  );

  typedef enum int {K_R, K_ADDI, K_LW, K_SW, K_BEQ, K_BNE, K_ILL} kind_t;
  typedef struct {
    bit halt;
    int cyc;
    int stg;
    int br;
    int aop;
    int fn;
    int src;
    int rd;
    int wr;
    int rw;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_ret = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: accumulate strobe activity per instruction, compare on retire / error rise.
  int acc_rd = 0, acc_wr = 0, acc_rw = 0;
  bit prev_err = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      acc_rd = 0; acc_wr = 0; acc_rw = 0; prev_err = 1'b0;
    end else begin
      acc_rd += int'(mem_read);
      acc_wr += int'(mem_write);
      acc_rw += int'(reg_write);
      if (error && prev_err)
        check("halt_quiet", 32'({stage, mem_read, mem_write, reg_write, pc_write, pc_branch}), 0);
      if (error && !prev_err) begin
        if (sb.size() == 0 || !sb[0].halt) begin
          check("unexpected_error", 32'(error), 0);
        end else begin
          e = sb.pop_front();
          check("halt_cycle", cyc, e.cyc);
          check("halt_stage", 32'(stage), e.stg);
          check("halt_mem_read_cycles", acc_rd, e.rd);
          check("halt_mem_write_cycles", acc_wr, e.wr);
          check("halt_reg_write", acc_rw, e.rw);
          acc_rd = 0; acc_wr = 0; acc_rw = 0;
        end
      end
      if (instr_done) begin
        if (sb.size() == 0 || sb[0].halt) begin
          check("unexpected_retire", 32'(instr_done), 0);
        end else begin
          e = sb.pop_front();
          check("retire_cycle", cyc, e.cyc);
          check("retire_stage", 32'(stage), e.stg);
          check("pc_write", 32'(pc_write), 1);
          check("pc_branch", 32'(pc_branch), e.br);
          check("alu_op", 32'(alu_op), e.aop);
          check("alu_funct", 32'(alu_funct), e.fn);
          check("ALU_Src", 32'(ALU_Src), e.src);
          check("mem_read_cycles", acc_rd, e.rd);
          check("mem_write_cycles", acc_wr, e.wr);
          check("reg_write_pulses", acc_rw, e.rw);
          check("instr_count", 32'(instr_count), e.cnt);
          check("error_at_retire", 32'(error), 0);
          acc_rd = 0; acc_wr = 0; acc_rw = 0;
        end
      end else begin
        check("no_stray_pc", 32'({pc_write, pc_branch}), 0);
      end
      prev_err = error;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      instr       = $urandom;
      instr_valid = 1'($urandom);
      mem_ready   = 1'($urandom);
      zero        = 1'($urandom);
    end
  endtask

  function automatic logic [5:0] opcode_of(input kind_t k);
    case (k)
      K_R:     return 6'b000000;
      K_ADDI:  return 6'b001000;
      K_LW:    return 6'b100011;
      K_SW:    return 6'b101011;
      K_BEQ:   return 6'b000100;
      K_BNE:   return 6'b000101;
      default: return 6'b111111;
    endcase
  endfunction

  // Driver + reference model: one instruction, w = MEM cycles without mem_ready.
  task automatic run_instr(input kind_t k, input int w, input bit z, input int gap,
                           input logic [25:0] low);
    exp_t e;
    int   c, len;
    logic [31:0] iw;
    tick();
    repeat (gap) begin
      instr = $urandom; instr_valid = 1'b0; mem_ready = 1'($urandom); zero = 1'($urandom);
      tick();
    end
    iw          = {opcode_of(k), low};
    instr       = iw;
    instr_valid = 1'b1;
    mem_ready   = 1'($urandom);
    zero        = 1'($urandom);
    c           = cyc;
    e = '{halt: 1'b0, cyc: 0, stg: 0, br: 0, aop: 0, fn: 0, src: 0, rd: 0, wr: 0, rw: 0,
          cnt: n_ret % (1 << CNT_W)};
    case (k)
      K_R:    begin e.fn = int'(iw[5:0]); len = 3; e.stg = 4; e.rw = 1; end
      K_ADDI: begin e.aop = 3; e.src = 1; len = 3; e.stg = 4; e.rw = 1; end
      K_LW, K_SW: begin
        e.aop = 3; e.src = 1;
        if (w >= TO) begin
          e.halt = 1'b1; len = 3 + TO;
          if (k == K_LW) e.rd = TO; else e.wr = TO;
        end else if (k == K_LW) begin
          len = 4 + w; e.stg = 4; e.rd = w + 1; e.rw = 1;
        end else begin
          len = 3 + w; e.stg = 3; e.wr = w + 1;
        end
      end
      K_BEQ:  begin e.aop = 1; len = 3; e.stg = 3; e.br = int'(z); end
      K_BNE:  begin e.aop = 1; len = 3; e.stg = 3; e.br = int'(!z); end
      default: begin e.halt = 1'b1; len = 2; end
    endcase
    e.cyc = c + len;
    if (!e.halt) n_ret++;
    sb.push_back(e);
    for (int j = 1; j <= len; j++) begin
      tick();
      instr       = $urandom;
      instr_valid = 1'($urandom);
      zero        = (j == 3) ? z : 1'($urandom);
      if ((k == K_LW || k == K_SW) && j >= 3) mem_ready = (j == 3 + w);
      else                                    mem_ready = 1'($urandom);
    end
  endtask

  task automatic do_reset();
    tick();
    @(negedge clock);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 0);
    check("count_before_reset", 32'(instr_count), n_ret % (1 << CNT_W));
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_outputs", 32'({stage, alu_op, alu_funct, ALU_Src, mem_read, mem_write,
                                reg_write, pc_write, pc_branch, instr_done, error}), 0);
    check("reset_count", 32'(instr_count), 0);
    sb.delete();
    n_ret       = 0;
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    kind_t k;
    int    w;
    #2 reset_n = 1'b0;
    #1;
    check("por_outputs", 32'({stage, alu_op, alu_funct, ALU_Src, mem_read, mem_write,
                              reg_write, pc_write, pc_branch, instr_done, error}), 0);
    check("por_count", 32'(instr_count), 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;

    run_instr(K_R,    0,  1'b0, 0, 26'h20);
    run_instr(K_LW,   3,  1'b0, 0, 26'($urandom));
    run_instr(K_BEQ,  0,  1'b1, 0, 26'($urandom));
    run_instr(K_BNE,  0,  1'b1, 1, 26'($urandom));
    run_instr(K_SW,   TO - 1, 1'b0, 0, 26'($urandom));
    run_instr(K_ADDI, 0,  1'b0, 2, 26'($urandom));

    for (int i = 0; i < 60; i++) begin
      k = kind_t'($urandom_range(0, 5));
      w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, TO - 1)) : int'($urandom_range(0, 3));
      run_instr(k, w, 1'($urandom), int'($urandom_range(0, 2)), 26'($urandom));
    end
    do_reset();

    run_instr(K_ILL, 0, 1'b0, 0, 26'($urandom));
    idle(6);
    do_reset();

    run_instr(K_SW, TO, 1'b0, 0, 26'($urandom));
    idle(4);
    do_reset();

    run_instr(K_LW, TO + 3, 1'b0, 1, 26'($urandom));
    idle(3);
    do_reset();

    // addi interrupted by reset while in EX
    tick();
    instr = {6'b001000, 26'($urandom)};
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    instr = $urandom;
    check("id_stage", 32'(stage), 1);
    check("id_alu_op", 32'(alu_op), 3);
    check("id_alu_src", 32'(ALU_Src), 1);
    tick();
    check("ex_stage", 32'(stage), 2);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_outputs", 32'({stage, alu_op, alu_funct, ALU_Src, mem_read, mem_write,
                                   reg_write, pc_write, pc_branch, instr_done, error}), 0);
    check("midreset_count", 32'(instr_count), 0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle(0);
    instr_valid = 1'b0;
    repeat (4) tick();
    check("after_midreset_count", 32'(instr_count), 0);
    check("after_midreset_queue", 32'(sb.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
